// File: rtl/pipelined_mac_unit_pkg.sv
// pipelined_mac_unit_pkg: shared constants and helpers for the pipelined MAC processing element
package pipelined_mac_unit_pkg;
  localparam int MAX_ACC_WIDTH = 64;
  localparam int MIN_MUL_STAGES = 1;
  localparam int MAX_MUL_STAGES = 4;
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction
  function automatic logic [63:0] sign_ext(input logic [63:0] v, input int w);
    return $signed(v << (64 - w)) >>> (64 - w);
  endfunction
  function automatic bit stages_ok(input int s);
    return s >= MIN_MUL_STAGES && s <= MAX_MUL_STAGES;
  endfunction
endpackage

// File: rtl/pipelined_mac_unit_mul_pipe.sv
// mul_pipe: signed multiplier with STAGES registers and a valid/clear/last/zero sideband
module mul_pipe #(
  parameter int I_WIDTH = 8,
  parameter int F_WIDTH = 8,
  parameter int STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid,
  input  logic [I_WIDTH-1:0]         feature,
  input  logic [F_WIDTH-1:0]         weight,
  input  logic                       clear,
  input  logic                       last,
  output logic [I_WIDTH+F_WIDTH-1:0] product,
  output logic                       p_valid,
  output logic                       p_clear,
  output logic                       p_last,
  output logic                       p_zero
);
  localparam int PW = I_WIDTH + F_WIDTH;
  logic signed [I_WIDTH-1:0] ha, ma;
  logic signed [F_WIDTH-1:0] hb, mb;
  logic signed [PW-1:0] prod;
  logic [PW-1:0] p [STAGES];
  logic [STAGES-1:0] v, c, l, z;
  logic zero, take;
  // multiplier operands are held at the last real pair on zero terms and bubbles so the array stays quiet
  always_comb begin
    zero = feature == '0 || weight == '0;
    take = valid && !zero;
    ma = take ? feature : ha;
    mb = take ? weight : hb;
    prod = PW'(ma) * PW'(mb);
  end
  // product and sideband shift register; zero-flagged terms carry a forced-zero product
  always_ff @(posedge clk) begin
    if (reset) begin
      ha <= '0;
      hb <= '0;
      v <= '0;
      c <= '0;
      l <= '0;
      z <= '0;
      for (int i = 0; i < STAGES; i++) p[i] <= '0;
    end else begin
      if (take) begin
        ha <= feature;
        hb <= weight;
      end
      v[0] <= valid;
      c[0] <= valid && clear;
      l[0] <= valid && last;
      z[0] <= valid && zero;
      p[0] <= (valid && !zero) ? prod : '0;
      for (int i = 1; i < STAGES; i++) begin
        v[i] <= v[i-1];
        c[i] <= c[i-1];
        l[i] <= l[i-1];
        z[i] <= z[i-1];
        p[i] <= p[i-1];
      end
    end
  end
  assign product = p[STAGES-1];
  assign p_valid = v[STAGES-1];
  assign p_clear = c[STAGES-1];
  assign p_last = l[STAGES-1];
  assign p_zero = z[STAGES-1];
endmodule

// File: rtl/pipelined_mac_unit.sv
// pipelined_mac_unit: pipelined signed MAC with zero skipping, framed accumulation and optional saturation
module pipelined_mac_unit
  import pipelined_mac_unit_pkg::*;
#(
  parameter int I_WIDTH = 8,
  parameter int F_WIDTH = 8,
  parameter int ACC_WIDTH = 32,
  parameter int MUL_STAGES = 2,
  parameter int SATURATE = 1,
  parameter int SKIP_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_i,
  input  logic [I_WIDTH-1:0]         in_feature_i,
  input  logic [F_WIDTH-1:0]         f_weight_i,
  input  logic                       acc_clear_i,
  input  logic                       acc_last_i,
  output logic [I_WIDTH+F_WIDTH-1:0] out_mul_o,
  output logic                       mul_valid_o,
  output logic [ACC_WIDTH-1:0]       acc_o,
  output logic                       acc_valid_o,
  output logic                       overflow_o,
  output logic [SKIP_CNT_WIDTH-1:0]  skip_count_o
);
  localparam int PW = I_WIDTH + F_WIDTH;
  localparam logic [ACC_WIDTH-1:0] SMAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] SMIN = ACC_WIDTH'(sat_min(ACC_WIDTH));
  if (!stages_ok(MUL_STAGES) || ACC_WIDTH < PW || ACC_WIDTH > MAX_ACC_WIDTH) begin : g_bad_params
    $error("pipelined_mac_unit: illegal MUL_STAGES or ACC_WIDTH");
  end
  logic m_clear, m_last, m_zero;
  logic [ACC_WIDTH-1:0] pe, base, res;
  logic [ACC_WIDTH:0] sum;
  logic ovf;
  mul_pipe #(.I_WIDTH(I_WIDTH), .F_WIDTH(F_WIDTH), .STAGES(MUL_STAGES)) u_mul (
    .clk(clk),
    .reset(reset),
    .valid(valid_i),
    .feature(in_feature_i),
    .weight(f_weight_i),
    .clear(acc_clear_i),
    .last(acc_last_i),
    .product(out_mul_o),
    .p_valid(mul_valid_o),
    .p_clear(m_clear),
    .p_last(m_last),
    .p_zero(m_zero)
  );
  // one-bit-wider sum exposes overflow as disagreement between the top two bits
  always_comb begin
    pe = ACC_WIDTH'(sign_ext(64'(out_mul_o), PW));
    base = m_clear ? '0 : acc_o;
    sum = {base[ACC_WIDTH-1], base} + {pe[ACC_WIDTH-1], pe};
    ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    res = (ovf && SATURATE != 0) ? (sum[ACC_WIDTH] ? SMIN : SMAX) : sum[ACC_WIDTH-1:0];
  end
  // accumulator, sticky overflow, completion pulse and saturating zero-skip counter
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_o <= '0;
      acc_valid_o <= 1'b0;
      overflow_o <= 1'b0;
      skip_count_o <= '0;
    end else begin
      acc_valid_o <= mul_valid_o && m_last;
      if (mul_valid_o) begin
        acc_o <= res;
        overflow_o <= (overflow_o && !m_clear) || ovf;
      end
      if (mul_valid_o && m_zero && !(&skip_count_o)) skip_count_o <= skip_count_o + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipelined_mac_unit.sv
// tb_pipelined_mac_unit: directed scoreboard bench over 32-bit saturating, 16-bit saturating and 16-bit wrapping MACs
module tb_pipelined_mac_unit;
  typedef struct {
    longint v;
    logic o;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic valid_i = 1'b0;
  logic acc_clear_i = 1'b0;
  logic acc_last_i = 1'b0;
  logic signed [7:0] in_feature_i = '0;
  logic signed [7:0] f_weight_i = '0;
  logic [15:0] mul_a, mul_s, mul_w, sk_a, sk_s, sk_w;
  logic [31:0] acc_a;
  logic [15:0] acc_s, acc_w;
  logic mv_a, mv_s, mv_w, av_a, av_s, av_w, ov_a, ov_s, ov_w;
  int cyc = 0;
  int lc = 0;
  int checks = 0;
  int failures = 0;
  exp_t mq[$], qa[$], qs[$], qw[$];
  exp_t em, ea, es, ew;

  pipelined_mac_unit #(.I_WIDTH(8), .F_WIDTH(8), .ACC_WIDTH(32), .MUL_STAGES(2), .SATURATE(1), .SKIP_CNT_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .valid_i(valid_i), .in_feature_i(in_feature_i), .f_weight_i(f_weight_i),
    .acc_clear_i(acc_clear_i), .acc_last_i(acc_last_i), .out_mul_o(mul_a), .mul_valid_o(mv_a),
    .acc_o(acc_a), .acc_valid_o(av_a), .overflow_o(ov_a), .skip_count_o(sk_a));
  pipelined_mac_unit #(.I_WIDTH(8), .F_WIDTH(8), .ACC_WIDTH(16), .MUL_STAGES(2), .SATURATE(1), .SKIP_CNT_WIDTH(16)) dut_s (
    .clk(clk), .reset(reset), .valid_i(valid_i), .in_feature_i(in_feature_i), .f_weight_i(f_weight_i),
    .acc_clear_i(acc_clear_i), .acc_last_i(acc_last_i), .out_mul_o(mul_s), .mul_valid_o(mv_s),
    .acc_o(acc_s), .acc_valid_o(av_s), .overflow_o(ov_s), .skip_count_o(sk_s));
  pipelined_mac_unit #(.I_WIDTH(8), .F_WIDTH(8), .ACC_WIDTH(16), .MUL_STAGES(2), .SATURATE(0), .SKIP_CNT_WIDTH(16)) dut_w (
    .clk(clk), .reset(reset), .valid_i(valid_i), .in_feature_i(in_feature_i), .f_weight_i(f_weight_i),
    .acc_clear_i(acc_clear_i), .acc_last_i(acc_last_i), .out_mul_o(mul_w), .mul_valid_o(mv_w),
    .acc_o(acc_w), .acc_valid_o(av_w), .overflow_o(ov_w), .skip_count_o(sk_w));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=pulse required=none (cycle %0d)", name, cyc);
  endtask

  task automatic term(input int f, input int w, input bit clr, input bit lst);
    @(negedge clk);
    valid_i = 1'b1;
    in_feature_i = 8'(f);
    f_weight_i = 8'(w);
    acc_clear_i = clr;
    acc_last_i = lst;
    lc = cyc;
    mq.push_back('{v: longint'(f * w), o: 1'b0, cyc: cyc + 2});
  endtask

  task automatic expect_acc(input longint a32, input bit o32, input longint a16s, input bit o16s, input longint a16w, input bit o16w);
    qa.push_back('{v: a32, o: o32, cyc: lc + 3});
    qs.push_back('{v: a16s, o: o16s, cyc: lc + 3});
    qw.push_back('{v: a16w, o: o16w, cyc: lc + 3});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_i = 1'b0;
      acc_clear_i = 1'b0;
      acc_last_i = 1'b0;
      in_feature_i = '0;
      f_weight_i = '0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_acc"}, acc_a, 0);
    chk({tag, "_acc_valid"}, av_a, 0);
    chk({tag, "_mul"}, mul_a, 0);
    chk({tag, "_mul_valid"}, mv_a, 0);
    chk({tag, "_ovf"}, ov_a, 0);
    chk({tag, "_skip"}, sk_a, 0);
    chk({tag, "_acc16"}, acc_s, 0);
  endtask

  always @(negedge clk) if (mv_a) begin
    if (mq.size() == 0) unexpected("mul_unexpected");
    else begin
      em = mq.pop_front();
      chk("mul_value", longint'($signed(mul_a)), em.v);
      chk("mul_latency", cyc, em.cyc);
    end
  end

  always @(negedge clk) if (av_a) begin
    if (qa.size() == 0) unexpected("acc32_unexpected");
    else begin
      ea = qa.pop_front();
      chk("acc32_value", longint'($signed(acc_a)), ea.v);
      chk("acc32_ovf", ov_a, ea.o);
      chk("acc32_latency", cyc, ea.cyc);
    end
  end

  always @(negedge clk) if (av_s) begin
    if (qs.size() == 0) unexpected("acc16sat_unexpected");
    else begin
      es = qs.pop_front();
      chk("acc16sat_value", longint'($signed(acc_s)), es.v);
      chk("acc16sat_ovf", ov_s, es.o);
      chk("acc16sat_latency", cyc, es.cyc);
    end
  end

  always @(negedge clk) if (av_w) begin
    if (qw.size() == 0) unexpected("acc16wrap_unexpected");
    else begin
      ew = qw.pop_front();
      chk("acc16wrap_value", longint'($signed(acc_w)), ew.v);
      chk("acc16wrap_ovf", ov_w, ew.o);
      chk("acc16wrap_latency", cyc, ew.cyc);
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    idle(2);
    term(3, -5, 1, 1);
    expect_acc(-15, 0, -15, 0, -15, 0);
    idle(5);
    term(2, 3, 1, 0);
    term(-4, 5, 0, 0);
    term(7, 7, 0, 0);
    term(-128, -128, 0, 1);
    expect_acc(16419, 0, 16419, 0, 16419, 0);
    idle(5);
    term(0, 9, 1, 0);
    term(4, 0, 0, 0);
    term(0, 0, 0, 0);
    term(2, 5, 0, 0);
    term(-3, 4, 0, 0);
    term(6, 6, 0, 1);
    expect_acc(34, 0, 34, 0, 34, 0);
    idle(5);
    chk("skip_count", sk_a, 3);
    chk("skip_count16", sk_w, 3);
    term(127, 127, 1, 0);
    term(127, 127, 0, 0);
    term(127, 127, 0, 1);
    expect_acc(48387, 0, 32767, 1, -17149, 1);
    idle(5);
    chk("ovf_sticky_sat", ov_s, 1);
    chk("ovf_sticky_wrap", ov_w, 1);
    chk("acc_hold_sat", longint'($signed(acc_s)), 32767);
    term(1, 1, 1, 1);
    expect_acc(1, 0, 1, 0, 1, 0);
    idle(5);
    chk("ovf_cleared", ov_s, 0);
    term(1, 4, 1, 0);
    term(2, 3, 0, 1);
    expect_acc(10, 0, 10, 0, 10, 0);
    term(2, 2, 1, 1);
    expect_acc(4, 0, 4, 0, 4, 0);
    idle(5);
    chk("acc_hold", longint'($signed(acc_a)), 4);
    term(5, 5, 1, 0);
    term(6, 6, 0, 0);
    @(negedge clk);
    valid_i = 1'b0;
    acc_clear_i = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    chk_zero("midreset");
    idle(6);
    chk("midreset_quiet_acc", acc_a, 0);
    term(1, 1, 1, 1);
    expect_acc(1, 0, 1, 0, 1, 0);
    idle(6);
    chk("drain_mul", mq.size(), 0);
    chk("drain_acc32", qa.size(), 0);
    chk("drain_acc16sat", qs.size(), 0);
    chk("drain_acc16wrap", qw.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
